// File: rtl/udt_rx_state_gate.sv
// rtl/udt_rx_state_gate.sv - UDT receive-side socket-state gate with 2-entry skid buffer
//
// Opens or closes the user RX AXI-Stream port according to the UDT socket
// state, only ever on packet boundaries, so the user sees whole packets.
//
// Optional feature macro: RX_DROP_EN
//   defined   : while CLOSED the core is drained (tready=1) and beats are
//               discarded; discarded packets are counted in drop_cnt_o.
//   undefined : while CLOSED the core is back-pressured; drop_cnt_o = 0.
//
// Ports:
//   rx_axis_aclk, rx_axis_aresetn   clock, asynchronous active-low reset
//   udt_state_i, state_valid_i      socket state code and its valid strobe
//   s_axis_*                        beats from the UDT core
//   m_axis_*                        beats to the user
//   conn_o                          gate is OPEN or DRAIN
//   pkt_cnt_o                       delivered packets (wrapping)
//   drop_cnt_o                      discarded packets (wrapping)

module udt_rx_state_gate #(
  parameter logic [31:0] CONNECT    = 32'h0000_0001,
  parameter logic [31:0] CLOSE      = 32'h0000_0002,
  parameter int          DATA_WIDTH = 32
) (
  input  logic                  rx_axis_aclk,
  input  logic                  rx_axis_aresetn,
  input  logic [31:0]           udt_state_i,
  input  logic                  state_valid_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
  input  logic                  s_axis_tvalid_i,
  input  logic                  s_axis_tlast_i,
  output logic                  s_axis_tready_o,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
  output logic                  m_axis_tvalid_o,
  output logic                  m_axis_tlast_o,
  input  logic                  m_axis_tready_i,
  output logic                  conn_o,
  output logic [15:0]           pkt_cnt_o,
  output logic [15:0]           drop_cnt_o
);

  typedef enum logic [1:0] {
    ST_CLOSED = 2'd0,
    ST_OPEN   = 2'd1,
    ST_DRAIN  = 2'd2
  } gate_state_t;

  gate_state_t           state_q, state_d;
  logic                  pend_q, pend_d;
  logic                  in_pkt_q, in_pkt_d;
  logic [1:0]            cnt_q;
  logic [DATA_WIDTH-1:0] head_data_q, tail_data_q;
  logic                  head_last_q, tail_last_q;
  logic [15:0]           pkt_cnt_q;

  logic pass, skid_full, closed_ready;
  logic s_acc, tlast_acc, push, pop;
  logic is_conn, is_close;

  assign pass      = (state_q != ST_CLOSED);
  assign skid_full = (cnt_q == 2'd2);

`ifdef RX_DROP_EN
  assign closed_ready = 1'b1;
`else
  assign closed_ready = 1'b0;
`endif

  // Ready depends on registered state only; reset forces it low.
  assign s_axis_tready_o = rx_axis_aresetn & (pass ? !skid_full : closed_ready);

  assign s_acc     = s_axis_tvalid_i & s_axis_tready_o;
  assign tlast_acc = s_acc & s_axis_tlast_i;
  assign push      = s_acc & pass;
  assign pop       = m_axis_tvalid_o & m_axis_tready_i;

  assign is_conn  = state_valid_i && (udt_state_i == CONNECT);
  assign is_close = state_valid_i && (udt_state_i == CLOSE);

  // Packet-boundary decisions look at in_pkt as it will be after this cycle,
  // so a first beat accepted alongside CLOSE/CONNECT is never split.
  assign in_pkt_d = s_acc ? !s_axis_tlast_i : in_pkt_q;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    unique case (state_q)
      ST_CLOSED: begin
        if (is_conn) begin
          pend_d = 1'b1;
        end else if (is_close) begin
          pend_d = 1'b0;
        end
        if ((is_conn || (pend_q && !is_close)) && !in_pkt_d) begin
          state_d = ST_OPEN;
          pend_d  = 1'b0;
        end
      end
      ST_OPEN: begin
        pend_d = 1'b0;
        if (is_close) begin
          state_d = in_pkt_d ? ST_DRAIN : ST_CLOSED;
        end
      end
      ST_DRAIN: begin
        pend_d = 1'b0;
        if (is_conn) begin
          state_d = ST_OPEN;
        end else if (tlast_acc) begin
          state_d = ST_CLOSED;
        end
      end
      default: begin
        state_d = ST_CLOSED;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge rx_axis_aclk or negedge rx_axis_aresetn) begin
    if (!rx_axis_aresetn) begin
      state_q  <= ST_CLOSED;
      pend_q   <= 1'b0;
      in_pkt_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      in_pkt_q <= in_pkt_d;
    end
  end

  // Skid buffer: head is always the beat presented to the user.
  always_ff @(posedge rx_axis_aclk or negedge rx_axis_aresetn) begin
    if (!rx_axis_aresetn) begin
      cnt_q       <= 2'd0;
      head_data_q <= '0;
      head_last_q <= 1'b0;
      tail_data_q <= '0;
      tail_last_q <= 1'b0;
    end else begin
      unique case (cnt_q)
        2'd0: begin
          if (push) begin
            head_data_q <= s_axis_tdata_i;
            head_last_q <= s_axis_tlast_i;
            cnt_q       <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_data_q <= s_axis_tdata_i;
            head_last_q <= s_axis_tlast_i;
          end else if (push) begin
            tail_data_q <= s_axis_tdata_i;
            tail_last_q <= s_axis_tlast_i;
            cnt_q       <= 2'd2;
          end else if (pop) begin
            cnt_q <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_data_q <= tail_data_q;
            head_last_q <= tail_last_q;
            cnt_q       <= 2'd1;
          end
        end
        default: cnt_q <= 2'd0;
      endcase
    end
  end

  always_ff @(posedge rx_axis_aclk or negedge rx_axis_aresetn) begin
    if (!rx_axis_aresetn) begin
      pkt_cnt_q <= 16'd0;
    end else if (pop && m_axis_tlast_o) begin
      pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

`ifdef RX_DROP_EN
  logic [15:0] drop_cnt_q;
  always_ff @(posedge rx_axis_aclk or negedge rx_axis_aresetn) begin
    if (!rx_axis_aresetn) begin
      drop_cnt_q <= 16'd0;
    end else if (tlast_acc && !pass) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end
  assign drop_cnt_o = drop_cnt_q;
`else
  assign drop_cnt_o = 16'd0;
`endif

  assign m_axis_tvalid_o = (cnt_q != 2'd0);
  assign m_axis_tdata_o  = head_data_q;
  assign m_axis_tlast_o  = head_last_q & m_axis_tvalid_o;
  assign conn_o          = pass;
  assign pkt_cnt_o       = pkt_cnt_q;

endmodule

// File: doc/udt_rx_state_gate.md
# udt_rx_state_gate

Receive-side counterpart of the UDT TX state gating. It sits between the UDT core's receive data output and the user's RX AXI-Stream port and opens or closes that port according to the UDT socket state (CONNECT/CLOSE). Packets are delivered whole: the gate opens and closes only on packet boundaries, and data passes through a 2-entry skid buffer. Delivered packets are counted, as are dropped packets when that feature is built in.

## Interface
Parameters:
- CONNECT, 32'h0000_0001, socket-state code that opens the gate
- CLOSE, 32'h0000_0002, socket-state code that closes the gate
- DATA_WIDTH, 32, AXIS tdata width

Ports:
- rx_axis_aclk  in  1  single block clock
- rx_axis_aresetn  in  1  asynchronous reset, active-low
- udt_state_i  in  32  UDT socket state, synchronous to rx_axis_aclk
- state_valid_i  in  1  udt_state_i valid / changed this cycle
- s_axis_tdata_i  in  DATA_WIDTH  data from UDT core
- s_axis_tvalid_i  in  1  core beat valid
- s_axis_tlast_i  in  1  core last beat of packet
- s_axis_tready_o  out  1  block ready to core
- m_axis_tdata_o  out  DATA_WIDTH  data to user
- m_axis_tvalid_o  out  1  user beat valid
- m_axis_tlast_o  out  1  user last beat
- m_axis_tready_i  in  1  user ready
- conn_o  out  1  gate state is OPEN or DRAIN
- pkt_cnt_o  out  16  packets delivered (m-side tlast handshakes), wraps
- drop_cnt_o  out  16  packets discarded, wraps; constant 0 without RX_DROP_EN

## Operation
- in_pkt flag: set on an accepted s-beat with tlast=0; cleared on an accepted s-beat with tlast=1.
- FSM states: CLOSED, OPEN, DRAIN. State changes are evaluated only when state_valid_i=1, except DRAIN→CLOSED.
  - CLOSED→OPEN: a pending CONNECT is present and in_pkt=0. A CONNECT seen while in_pkt=1 stays pending; OPEN is entered on the cycle after the discarding tlast.
  - OPEN→CLOSED: CLOSE arrives and either in_pkt=0 or a tlast is being accepted this cycle.
  - OPEN→DRAIN: CLOSE arrives and in_pkt=1 with no tlast accepted this cycle.
  - DRAIN→CLOSED: an s-side tlast is accepted. A CONNECT arriving in DRAIN cancels the drain and returns the FSM to OPEN.
  - Any other udt_state_i code: ignored. A CLOSE arriving in CLOSED clears a pending CONNECT.
- Pass mode (OPEN or DRAIN): s_axis_tready_o = !skid_full. Accepted beats enter the skid buffer.
- CLOSED mode: see Configuration. Beats are never written into the skid buffer.
- Skid buffer: 2 entries, FIFO order. Beats already buffered drain to the user regardless of FSM state.
- Accept/pass decision uses the current-cycle FSM state. A beat accepted on the cycle CLOSE arrives is forwarded.

## Timing
- Reset values: FSM=CLOSED, in_pkt=0, pending CONNECT=0, skid empty, m_axis_tvalid_o=0, m_axis_tlast_o=0, m_axis_tdata_o=0, conn_o=0, pkt_cnt_o=0, drop_cnt_o=0, s_axis_tready_o=0 while rx_axis_aresetn is low.
- Reset mid-packet flushes the buffer. No partial packet is emitted after reset.
- Latency: a beat accepted at edge N is presented on m_axis at edge N+1 when the buffer was empty.
- Throughput: 1 beat/cycle sustained while m_axis_tready_i=1.
- s_axis_tready_o is derived from registered state only; there is no combinational path from m_axis_tready_i.
- m_axis_tvalid_o, once high, holds with stable data and tlast until m_axis_tready_i=1.
- Gate latency: state_valid_i with CONNECT at edge N (in_pkt=0) gives FSM=OPEN and conn_o=1 after edge N, with first accept possible in cycle N+1.
- Counters increment by 1 per event and wrap from 16'hFFFF to 0.

## Configuration
- RX_DROP_EN defined: in CLOSED, s_axis_tready_o=1 and beats are discarded. drop_cnt_o increments on each discarded tlast beat. in_pkt still tracks discarded beats, so a reopen waits for the packet boundary.
- RX_DROP_EN undefined: in CLOSED, s_axis_tready_o=0 and the core is back-pressured. drop_cnt_o is tied to 0.

## Test plan
- Reset, then CONNECT pulse, then 4-beat packet with m_tready=1 → beats appear 1 cycle after acceptance, conn_o=1, pkt_cnt_o=1.
- CLOSE after beat 2 of a 4-beat packet → FSM=DRAIN, beats 3-4 delivered, CLOSED after tlast, s_tready_o=0 (no DROP_EN), pkt_cnt_o=1.
- m_tready_i low for 5 cycles mid-packet → at most 2 beats buffered, s_tready_o=0, no beat lost or duplicated, data order preserved.
- RX_DROP_EN, CLOSED, 3-beat packet sent, CONNECT after beat 1 → packet discarded, drop_cnt_o=1, OPEN after tlast, next packet delivered.
- CLOSE coincident with an accepted tlast in OPEN → that beat delivered, FSM=CLOSED directly, no DRAIN.
- Reset asserted with 2 beats buffered → m_tvalid_o=0 immediately, counters 0, conn_o=0.
